// File: rtl/dmem_dma_ctrl.sv
// Data-memory port arbiter with a copy/fill block-move engine; the CPU always wins the port.
// Optional DMEM_DMA_STALL_CNT_EN adds a 16-bit saturating count of engine cycles lost to the CPU.
module dmem_dma_ctrl #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_wr_en,
   input  logic [DW-1:0] cpu_dat_in,
   output logic [DW-1:0] cpu_dat_out,
   input  logic          dma_start,
   input  logic          dma_fill,
   input  logic [AW-1:0] dma_src,
   input  logic [AW-1:0] dma_dst,
   input  logic [AW-1:0] dma_len,
   input  logic [DW-1:0] dma_fill_val,
   output logic          dma_busy,
   output logic          dma_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_dat_in,
   input  logic [DW-1:0] mem_dat_out
`ifdef DMEM_DMA_STALL_CNT_EN
   ,
   output logic [15:0]   dma_stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t        state;
   logic [AW-1:0] src_ptr, dst_ptr, cnt;
   logic [DW-1:0] byte_reg;
   logic          fill_mode;
   logic          gnt_dma;

   assign gnt_dma     = !cpu_req && (state == RD || state == WR);
   assign dma_busy    = (state != IDLE);
   assign dma_done    = (state == DONE);
   assign cpu_dat_out = mem_dat_out;

   always_comb begin
      mem_addr   = cpu_addr;
      mem_wr_en  = cpu_req & cpu_wr_en;
      mem_dat_in = cpu_dat_in;
      if (gnt_dma) begin
         mem_addr   = (state == RD) ? src_ptr : dst_ptr;
         mem_wr_en  = (state == WR);
         mem_dat_in = byte_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         cnt       <= '0;
         byte_reg  <= '0;
         fill_mode <= 1'b0;
      end else begin
         case (state)
            IDLE: if (dma_start) begin
               if (dma_len != '0) begin
                  src_ptr   <= dma_src;
                  dst_ptr   <= dma_dst;
                  cnt       <= dma_len;
                  fill_mode <= dma_fill;
                  if (dma_fill) byte_reg <= dma_fill_val;
                  state     <= dma_fill ? WR : RD;
               end else begin
                  state <= DONE;
               end
            end
            RD: if (gnt_dma) begin
               byte_reg <= mem_dat_out;
               src_ptr  <= src_ptr + 1'b1;
               state    <= WR;
            end
            WR: if (gnt_dma) begin
               dst_ptr <= dst_ptr + 1'b1;
               cnt     <= cnt - 1'b1;
               // Fill mode never revisits RD; byte_reg keeps the fill value.
               if (cnt == AW'(1)) state <= DONE;
               else               state <= fill_mode ? WR : RD;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_DMA_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dma_stall_cnt <= '0;
      else if (state == IDLE && dma_start)
         dma_stall_cnt <= '0;
      else if ((state == RD || state == WR) && cpu_req && dma_stall_cnt != 16'hFFFF)
         dma_stall_cnt <= dma_stall_cnt + 16'd1;
   end
`endif

endmodule
